// File: rtl/tx_serializer_pkg.sv
// Shared types and constants for the TX serializer.
package tx_serializer_pkg;

  // Frame sequencing states; the three unused codes fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity mode selector values.
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-period timer: bit_done_o is high in the last cycle of each serial bit.
module tx_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             bit_done_q, bit_done_d;

  // Next count and a registered terminal-count flag aligned with count_q.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear_i || (count_q == CNT_LAST)) begin
      count_d = '0;
    end
    bit_done_d = (count_d == CNT_LAST);
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      bit_done_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      bit_done_q <= bit_done_d;
    end
  end

  assign bit_done_o = bit_done_q;

endmodule

// File: rtl/tx_serializer.sv
// Async-frame transmitter: start bit, LSB-first data, optional parity, stop bits.
module tx_serializer
  import tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              TX_Data_Valid,
  input  logic [DATA_W-1:0] TX_Data,
  output logic              TX_Data_Ready,
  output logic              tx_serial,
  output logic              tx_busy
);

  localparam int unsigned CNT_MAX   = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int unsigned BIT_CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_serial_q, tx_serial_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  bit_done;
  logic                  baud_clear;

  assign accept     = TX_Data_Valid & ready_q;
  assign baud_clear = (state_q == ST_IDLE);

  tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (baud_clear),
    .bit_done_o(bit_done)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    parity_d    = parity_q;
    tx_serial_d = 1'b1;
    ready_d     = 1'b0;
    busy_d      = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          shift_d     = TX_Data;
          parity_d    = (PARITY == PARITY_ODD) ? ~^TX_Data : ^TX_Data;
          state_d     = ST_START;
          tx_serial_d = 1'b0;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_START: begin
        tx_serial_d = 1'b0;
        if (bit_done) begin
          state_d     = ST_DATA;
          bit_cnt_d   = '0;
          tx_serial_d = shift_q[0];
        end
      end
      ST_DATA: begin
        tx_serial_d = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d     = ST_PARITY;
              tx_serial_d = parity_q;
            end else begin
              state_d     = ST_STOP;
              tx_serial_d = 1'b1;
            end
          end else begin
            bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
            tx_serial_d = shift_d[0];
          end
        end
      end
      ST_PARITY: begin
        tx_serial_d = parity_q;
        if (bit_done) begin
          state_d     = ST_STOP;
          bit_cnt_d   = '0;
          tx_serial_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      tx_serial_q <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      tx_serial_q <= tx_serial_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign TX_Data_Ready = ready_q;
  assign tx_serial     = tx_serial_q;
  assign tx_busy       = busy_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: four instances (no parity, even, odd, two stop bits).
module tb_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic [3:0] rdy, busy, line;

  int checks = 0;
  int errors = 0;

  logic wl [4][96];
  logic wr [4][96];
  logic wb [4][96];

  always #5 clk = ~clk;

  tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .rst(rst), .TX_Data_Valid(valid), .TX_Data(data),
    .TX_Data_Ready(rdy[0]), .tx_serial(line[0]), .tx_busy(busy[0]));
  tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_pe (
    .clk(clk), .rst(rst), .TX_Data_Valid(valid), .TX_Data(data),
    .TX_Data_Ready(rdy[1]), .tx_serial(line[1]), .tx_busy(busy[1]));
  tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_po (
    .clk(clk), .rst(rst), .TX_Data_Valid(valid), .TX_Data(data),
    .TX_Data_Ready(rdy[2]), .tx_serial(line[2]), .tx_busy(busy[2]));
  tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst(rst), .TX_Data_Valid(valid), .TX_Data(data),
    .TX_Data_Ready(rdy[3]), .tx_serial(line[3]), .tx_busy(busy[3]));

  // Reference line level at cycle k after accept (4 clocks per bit).
  function automatic logic exp_line(input logic [7:0] d, input int par, input int k);
    int b;
    b = k / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par != 0 && b == 9) return (par == 2) ? ~^d : ^d;
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Present one word for a single accept edge, then scramble TX_Data.
  task automatic start_frame(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
    data  = ~d;
  endtask

  task automatic capture(input int base, input int n);
    for (int k = base; k < base + n; k++) begin
      for (int u = 0; u < 4; u++) begin
        wl[u][k] = line[u];
        wr[u][k] = rdy[u];
        wb[u][k] = busy[u];
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({line[0], rdy[0], busy[0]} !== 3'b100) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got line/rdy/busy=%b exp 100", i, {line[0], rdy[0], busy[0]});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({line[0], rdy[0], busy[0]} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release got line/rdy/busy=%b exp 110", {line[0], rdy[0], busy[0]});
    end
  endtask

  task automatic test_basic();
    logic [9:0] frame;
    frame = 10'b1101001010;  // A5: start, 1,0,1,0,0,1,0,1, stop (bit 0 first)
    do_reset();
    start_frame(8'hA5);
    capture(0, 42);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (wl[0][k] !== frame[k/4] || wr[0][k] !== 1'b0 || wb[0][k] !== 1'b1) begin
        errors++;
        $display("FAIL basic_frame k=%0d got line/rdy/busy=%b%b%b exp %b01", k, wl[0][k], wr[0][k], wb[0][k], frame[k/4]);
      end
    end
    for (int k = 40; k < 42; k++) begin
      checks++;
      if ({wl[0][k], wr[0][k], wb[0][k]} !== 3'b110) begin
        errors++;
        $display("FAIL basic_end k=%0d got line/rdy/busy=%b%b%b exp 110", k, wl[0][k], wr[0][k], wb[0][k]);
      end
    end
  endtask

  task automatic test_parity();
    do_reset();
    start_frame(8'hA5);
    capture(0, 46);
    for (int u = 1; u <= 2; u++) begin
      for (int k = 0; k < 44; k++) begin
        checks++;
        if (wl[u][k] !== exp_line(8'hA5, u, k) || wr[u][k] !== 1'b0) begin
          errors++;
          $display("FAIL parity_frame dut=%0d k=%0d got line=%b rdy=%b exp line=%b rdy=0", u, k, wl[u][k], wr[u][k], exp_line(8'hA5, u, k));
        end
      end
      checks++;
      if ({wl[u][44], wr[u][44], wb[u][44]} !== 3'b110) begin
        errors++;
        $display("FAIL parity_end dut=%0d got line/rdy/busy=%b%b%b exp 110", u, wl[u][44], wr[u][44], wb[u][44]);
      end
    end
    checks++;
    if ({wl[1][37], wl[2][37]} !== 2'b01) begin
      errors++;
      $display("FAIL parity_a5_bit got even/odd=%b%b exp 01", wl[1][37], wl[2][37]);
    end
    do_reset();
    start_frame(8'h01);
    capture(0, 46);
    checks++;
    if ({wl[1][38], wl[2][38]} !== 2'b10) begin
      errors++;
      $display("FAIL parity_01_bit got even/odd=%b%b exp 10", wl[1][38], wl[2][38]);
    end
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (wl[1][k] !== exp_line(8'h01, 1, k)) begin
        errors++;
        $display("FAIL parity_01_frame k=%0d got %b exp %b", k, wl[1][k], exp_line(8'h01, 1, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    valid = 1'b1;
    data  = 8'h3C;
    @(negedge clk);
    for (int k = 0; k < 84; k++) begin
      for (int u = 0; u < 4; u++) begin
        wl[u][k] = line[u];
        wr[u][k] = rdy[u];
        wb[u][k] = busy[u];
      end
      if (k == 0) data = 8'hC3;
      if (k == 41) begin
        valid = 1'b0;
        data  = 8'h00;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (wl[0][k] !== exp_line(8'h3C, 0, k) || wr[0][k] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame1 k=%0d got line=%b rdy=%b exp line=%b rdy=0", k, wl[0][k], wr[0][k], exp_line(8'h3C, 0, k));
      end
    end
    checks++;
    if ({wl[0][40], wr[0][40], wb[0][40]} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_gap got line/rdy/busy=%b%b%b exp 110", wl[0][40], wr[0][40], wb[0][40]);
    end
    for (int k = 41; k < 81; k++) begin
      checks++;
      if (wl[0][k] !== exp_line(8'hC3, 0, k - 41) || wr[0][k] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame2 k=%0d got line=%b rdy=%b exp line=%b rdy=0", k, wl[0][k], wr[0][k], exp_line(8'hC3, 0, k - 41));
      end
    end
    for (int k = 81; k < 84; k++) begin
      checks++;
      if ({wl[0][k], wr[0][k], wb[0][k]} !== 3'b110) begin
        errors++;
        $display("FAIL b2b_end k=%0d got line/rdy/busy=%b%b%b exp 110", k, wl[0][k], wr[0][k], wb[0][k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_frame(8'hF0);
    capture(0, 12);
    checks++;
    if (line[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre got line=%b exp 0", line[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({line[0], rdy[0], busy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL midrst_abort got line/rdy/busy=%b exp 100", {line[0], rdy[0], busy[0]});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({line[0], rdy[0], busy[0]} !== 3'b110) begin
      errors++;
      $display("FAIL midrst_release got line/rdy/busy=%b exp 110", {line[0], rdy[0], busy[0]});
    end
    capture(0, 8);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wl[0][k] !== 1'b1 || wb[0][k] !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet k=%0d got line=%b busy=%b exp 1 0", k, wl[0][k], wb[0][k]);
      end
    end
    start_frame(8'h5A);
    capture(0, 41);
    for (int k = 0; k < 41; k++) begin
      checks++;
      if (wl[0][k] !== exp_line(8'h5A, 0, k) || wr[0][k] !== (k == 40)) begin
        errors++;
        $display("FAIL midrst_next k=%0d got line=%b rdy=%b exp line=%b", k, wl[0][k], wr[0][k], exp_line(8'h5A, 0, k));
      end
    end
  endtask

  task automatic test_stop2();
    do_reset();
    start_frame(8'hA5);
    capture(0, 46);
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (wl[3][k] !== exp_line(8'hA5, 0, k) || wr[3][k] !== 1'b0 || wb[3][k] !== 1'b1) begin
        errors++;
        $display("FAIL stop2_frame k=%0d got line/rdy/busy=%b%b%b exp %b01", k, wl[3][k], wr[3][k], wb[3][k], exp_line(8'hA5, 0, k));
      end
    end
    checks++;
    if ({wl[3][44], wr[3][44], wb[3][44]} !== 3'b110) begin
      errors++;
      $display("FAIL stop2_end got line/rdy/busy=%b%b%b exp 110", wl[3][44], wr[3][44], wb[3][44]);
    end
    checks++;
    if ({wr[0][40], wr[3][40]} !== 2'b10) begin
      errors++;
      $display("FAIL stop2_len got rdy1stop/rdy2stop at 40=%b%b exp 10", wr[0][40], wr[3][40]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_stop2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
